// File: rtl/pixel_stream_receiver_pkg.sv
// Shared widths, state encoding and geometry defaults for the packed-RGB stream sink.
package pixel_stream_receiver_pkg;

  localparam int STREAM_W   = 32;
  localparam int KEEP_W     = 4;
  localparam int PIX_W      = 24;
  localparam int COORD_W    = 11;
  localparam int X_SIZE_DEF = 1920;
  localparam int Y_SIZE_DEF = 1080;

  typedef enum logic [2:0] {
    SYNC  = 3'd0,
    W0    = 3'd1,
    W1    = 3'd2,
    W2    = 3'd3,
    EMIT3 = 3'd4
  } rx_state_t;

  // Three bus words carry four pixels, so a line is X_SIZE*3/4 words long.
  function automatic int words_per_line(input int x_size);
    return x_size * 3 / 4;
  endfunction

endpackage

// File: rtl/pixel_stream_receiver_if.sv
// AXI4-Stream input and valid/ready pixel output of the stream sink.
interface pixel_stream_receiver_if;
  import pixel_stream_receiver_pkg::*;

  logic [STREAM_W-1:0] in_stream_tdata;
  logic [KEEP_W-1:0]   in_stream_tkeep;
  logic                in_stream_tlast;
  logic                in_stream_tuser;
  logic                in_stream_tvalid;
  logic                in_stream_tready;

  logic [7:0]          pix_r;
  logic [7:0]          pix_g;
  logic [7:0]          pix_b;
  logic [COORD_W-1:0]  pix_x;
  logic [COORD_W-1:0]  pix_y;
  logic                pix_sof;
  logic                pix_eol;
  logic                pix_valid;
  logic                pix_ready;

  modport slave (
    input  in_stream_tdata, in_stream_tkeep, in_stream_tlast, in_stream_tuser,
           in_stream_tvalid, pix_ready,
    output in_stream_tready, pix_r, pix_g, pix_b, pix_x, pix_y, pix_sof,
           pix_eol, pix_valid
  );

  modport master (
    output in_stream_tdata, in_stream_tkeep, in_stream_tlast, in_stream_tuser,
           in_stream_tvalid, pix_ready,
    input  in_stream_tready, pix_r, pix_g, pix_b, pix_x, pix_y, pix_sof,
           pix_eol, pix_valid
  );

endinterface

// File: rtl/pixel_stream_receiver_unpacker.sv
// Steers bytes of each 32-bit word into 24-bit pixels; the residue holds the split pixel.
module pixel_stream_receiver_unpacker
  import pixel_stream_receiver_pkg::*;
(
  input  logic                aclk,
  input  logic                aresetn,
  input  rx_state_t           phase,
  input  logic                word_load,
  input  logic [STREAM_W-1:0] word,
  output logic [PIX_W-1:0]    pixel
);

  logic [PIX_W-1:0] residue;

  always_comb begin
    pixel = residue;
    case (phase)
      W0:      pixel = word[23:0];
      W1:      pixel = {word[15:0], residue[7:0]};
      W2:      pixel = {word[7:0], residue[15:0]};
      default: pixel = residue;
    endcase
  end

  // After W2 the residue is a whole pixel (P3), drained during EMIT3.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      residue <= '0;
    end else if (word_load) begin
      case (phase)
        W0:      residue <= {16'd0, word[31:24]};
        W1:      residue <= {8'd0, word[31:16]};
        W2:      residue <= word[31:8];
        default: residue <= residue;
      endcase
    end
  end

endmodule

// File: rtl/pixel_stream_receiver.sv
// AXI4-Stream packed-RGB video sink: unpacks pixels, tracks frame geometry,
// counts frames and checksums each completed frame.
module pixel_stream_receiver
  import pixel_stream_receiver_pkg::*;
#(
  parameter int X_SIZE = X_SIZE_DEF,
  parameter int Y_SIZE = Y_SIZE_DEF,
  parameter int CNT_W  = 16
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  pixel_stream_receiver_if.slave bus,
  input  logic                   err_clear,
  output logic [CNT_W-1:0]       frame_count,
  output logic [31:0]            checksum,
  output logic                   checksum_valid,
  output logic                   err_sof,
  output logic                   err_eol,
  output logic                   err_keep
);

  localparam logic [COORD_W-1:0] LAST_X   = COORD_W'(X_SIZE - 1);
  localparam logic [COORD_W-1:0] LAST_Y   = COORD_W'(Y_SIZE - 1);
  localparam logic [COORD_W-1:0] EOL_P2_X = COORD_W'(words_per_line(X_SIZE) / 3 * 4 - 2);

  rx_state_t          state;
  rx_state_t          grp;
  logic               ready_en;
  logic               out_free;
  logic               word_acc;
  logic               at_origin;
  logic               restart;
  logic               processed;
  logic               load_px;
  logic               exp_last;
  logic               last_x;
  logic               last_y;
  logic               sof_set;
  logic               eol_set;
  logic               keep_set;
  logic [COORD_W-1:0] cur_x;
  logic [COORD_W-1:0] cur_y;
  logic [COORD_W-1:0] load_x;
  logic [COORD_W-1:0] load_y;
  logic [31:0]        run_sum;
  logic [31:0]        sum_next;
  logic [PIX_W-1:0]   pixel;

  // ready_en keeps tready low through reset and the first cycle after it.
  assign out_free             = !bus.pix_valid || bus.pix_ready;
  assign bus.in_stream_tready = ready_en && out_free && (state != EMIT3);
  assign word_acc             = bus.in_stream_tvalid && bus.in_stream_tready;
  assign at_origin            = (cur_x == '0) && (cur_y == '0);

  // A tuser word anywhere except the expected frame start restarts at (0,0).
  assign restart   = word_acc && bus.in_stream_tuser && !((state == W0) && at_origin);
  assign processed = word_acc && ((state != SYNC) || bus.in_stream_tuser);
  assign grp       = restart ? W0 : state;
  assign load_px   = processed || ((state == EMIT3) && out_free);
  assign load_x    = restart ? '0 : cur_x;
  assign load_y    = restart ? '0 : cur_y;
  assign last_x    = (load_x == LAST_X);
  assign last_y    = (load_y == LAST_Y);
  assign exp_last  = (grp == W2) && (load_x == EOL_P2_X);
  assign sum_next  = (restart ? 32'd0 : run_sum) + {8'd0, pixel};

  assign sof_set  = word_acc && (state != SYNC) &&
                    (bus.in_stream_tuser != ((state == W0) && at_origin));
  assign eol_set  = processed && (bus.in_stream_tlast != exp_last);
  assign keep_set = word_acc && (bus.in_stream_tkeep != '1);

  pixel_stream_receiver_unpacker u_unpacker (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .phase     (grp),
    .word_load (processed),
    .word      (bus.in_stream_tdata),
    .pixel     (pixel)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state          <= SYNC;
      ready_en       <= 1'b0;
      cur_x          <= '0;
      cur_y          <= '0;
      run_sum        <= '0;
      bus.pix_r      <= '0;
      bus.pix_g      <= '0;
      bus.pix_b      <= '0;
      bus.pix_x      <= '0;
      bus.pix_y      <= '0;
      bus.pix_sof    <= 1'b0;
      bus.pix_eol    <= 1'b0;
      bus.pix_valid  <= 1'b0;
      frame_count    <= '0;
      checksum       <= '0;
      checksum_valid <= 1'b0;
      err_sof        <= 1'b0;
      err_eol        <= 1'b0;
      err_keep       <= 1'b0;
    end else begin
      ready_en       <= 1'b1;
      checksum_valid <= 1'b0;

      if (processed) begin
        case (grp)
          W0:      state <= W1;
          W1:      state <= W2;
          default: state <= EMIT3;
        endcase
      end else if ((state == EMIT3) && out_free) begin
        state <= W0;
      end

      if (load_px) begin
        {bus.pix_r, bus.pix_g, bus.pix_b} <= pixel;
        bus.pix_x     <= load_x;
        bus.pix_y     <= load_y;
        bus.pix_sof   <= (load_x == '0) && (load_y == '0);
        bus.pix_eol   <= last_x;
        bus.pix_valid <= 1'b1;
        cur_x         <= last_x ? '0 : load_x + COORD_W'(1);
        if (last_x) cur_y <= last_y ? '0 : load_y + COORD_W'(1);
        else        cur_y <= load_y;
        if (last_x && last_y) begin
          frame_count    <= frame_count + CNT_W'(1);
          checksum       <= sum_next;
          checksum_valid <= 1'b1;
          run_sum        <= '0;
        end else begin
          run_sum <= sum_next;
        end
      end else if (bus.pix_ready) begin
        bus.pix_valid <= 1'b0;
      end

      err_sof  <= !err_clear && (err_sof  || sof_set);
      err_eol  <= !err_clear && (err_eol  || eol_set);
      err_keep <= !err_clear && (err_keep || keep_set);
    end
  end

endmodule

// File: tb/tb_pixel_stream_receiver.sv
// Scoreboard bench for pixel_stream_receiver on a reduced 8x4 frame geometry.
module tb_pixel_stream_receiver;
  import pixel_stream_receiver_pkg::*;

  localparam int XS  = 8;
  localparam int YS  = 4;
  localparam int WPL = XS * 3 / 4;
  localparam int WPF = WPL * YS;

  typedef struct {
    logic [23:0] pix;
    int          x;
    int          y;
    bit          sof;
    bit          eol;
  } exp_t;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        err_clear = 1'b0;
  logic [15:0] frame_count;
  logic [31:0] checksum;
  logic        checksum_valid;
  logic        err_sof, err_eol, err_keep;

  int          n_checks = 0;
  int          n_pass = 0;
  int          n_cs_pulses = 0;
  bit          bp_en = 1'b0;
  bit          stalled = 1'b0;
  logic [63:0] held = '0;
  logic [31:0] exp_sum = '0;
  exp_t        q[$];

  pixel_stream_receiver_if bus();

  pixel_stream_receiver #(.X_SIZE(XS), .Y_SIZE(YS), .CNT_W(16)) dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .bus            (bus),
    .err_clear      (err_clear),
    .frame_count    (frame_count),
    .checksum       (checksum),
    .checksum_valid (checksum_valid),
    .err_sof        (err_sof),
    .err_eol        (err_eol),
    .err_keep       (err_keep)
  );

  always #5 aclk = ~aclk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  function automatic logic [23:0] gen_pix(input int seed, input int i);
    logic [31:0] t;
    if (seed == 1 && i < 4) begin
      case (i)
        0:       return 24'h332211;
        1:       return 24'h554444;
        2:       return 24'h887766;
        default: return 24'hCCBBAA;
      endcase
    end
    t = 32'(seed) * 32'h9E3779B1 + 32'(i) * 32'h85EBCA6B;
    return t[31:8];
  endfunction

  function automatic logic [63:0] pix_snapshot();
    return {15'd0, bus.pix_valid, bus.pix_r, bus.pix_g, bus.pix_b,
            bus.pix_x, bus.pix_y, bus.pix_sof, bus.pix_eol};
  endfunction

  task automatic applyStimulus(input logic [31:0] d, input logic user, input logic last,
                               input logic [3:0] keep);
    int c = 0;
    @(negedge aclk);
    bus.in_stream_tdata  = d;
    bus.in_stream_tuser  = user;
    bus.in_stream_tlast  = last;
    bus.in_stream_tkeep  = keep;
    bus.in_stream_tvalid = 1'b1;
    while (!bus.in_stream_tready && c < 1000) begin
      @(negedge aclk);
      c++;
    end
    if (!bus.in_stream_tready) checkOutput("tready_timeout", 64'(bus.in_stream_tready), 64'd1);
    else begin
      @(posedge aclk);
      #1;
    end
  endtask

  // Words [w_from, w_to) of a frame built from seed; pixels pushed as each group starts.
  task automatic send_words(input int seed, input int w_from, input int w_to, input bit sof,
                            input int bad_last, input int bad_keep, input bit clr);
    logic [23:0] p[4];
    logic [31:0] word;
    exp_t        e;
    int          g, ph, idx;
    for (int w = w_from; w < w_to; w++) begin
      g  = w / 3;
      ph = w % 3;
      for (int k = 0; k < 4; k++) p[k] = gen_pix(seed, 4 * g + k);
      if (ph == 0) begin
        for (int k = 0; k < 4; k++) begin
          idx   = 4 * g + k;
          if (idx == 0) exp_sum = '0;
          e.pix = p[k];
          e.x   = idx % XS;
          e.y   = idx / XS;
          e.sof = (idx == 0);
          e.eol = (e.x == XS - 1);
          exp_sum = exp_sum + {8'd0, p[k]};
          q.push_back(e);
        end
      end
      case (ph)
        0:       word = {p[1][7:0], p[0]};
        1:       word = {p[2][15:0], p[1][23:8]};
        default: word = {p[3], p[2][23:16]};
      endcase
      err_clear = clr;
      applyStimulus(word, sof && (w == 0),
                    ((ph == 2) && ((w % WPL) == WPL - 1)) ^ (w == bad_last),
                    (w == bad_keep) ? 4'h7 : 4'hF);
    end
    bus.in_stream_tvalid = 1'b0;
    err_clear = 1'b0;
  endtask

  task automatic wait_drain();
    int c = 0;
    while (q.size() != 0 && c < 500) begin
      @(negedge aclk);
      c++;
    end
    if (q.size() != 0) begin
      checkOutput("drain_timeout", 64'(q.size()), 64'd0);
      q.delete();
    end
  endtask

  // 30% backpressure when enabled; changed just after the edge so it is settled by negedge.
  always @(posedge aclk) begin
    #1;
    bus.pix_ready = bp_en ? ($urandom_range(0, 99) >= 30) : 1'b1;
  end

  always @(negedge aclk) begin : monitor
    exp_t e;
    if (aresetn) begin
      if (stalled) checkOutput("stall_hold", pix_snapshot(), held);
      if (bus.pix_valid && bus.pix_ready) begin
        if (q.size() == 0) checkOutput("unexpected_pixel", 64'd1, 64'd0);
        else begin
          e = q.pop_front();
          checkOutput("pix_data", 64'({bus.pix_r, bus.pix_g, bus.pix_b}), 64'(e.pix));
          checkOutput("pix_x", 64'(bus.pix_x), 64'(e.x));
          checkOutput("pix_y", 64'(bus.pix_y), 64'(e.y));
          checkOutput("pix_sof", 64'(bus.pix_sof), 64'(e.sof));
          checkOutput("pix_eol", 64'(bus.pix_eol), 64'(e.eol));
        end
      end
      stalled = bus.pix_valid && !bus.pix_ready;
      held    = pix_snapshot();
      if (checksum_valid) n_cs_pulses++;
    end else begin
      stalled = 1'b0;
    end
  end

  initial begin
    bus.in_stream_tdata  = '0;
    bus.in_stream_tkeep  = '0;
    bus.in_stream_tlast  = 1'b0;
    bus.in_stream_tuser  = 1'b0;
    bus.in_stream_tvalid = 1'b0;
    bus.pix_ready        = 1'b1;

    #12;
    checkOutput("reset_tready", 64'(bus.in_stream_tready), 64'd0);
    checkOutput("reset_pix_valid", 64'(bus.pix_valid), 64'd0);
    checkOutput("reset_frame_count", 64'(frame_count), 64'd0);
    checkOutput("reset_checksum", 64'(checksum), 64'd0);
    checkOutput("reset_errors", 64'({err_sof, err_eol, err_keep, checksum_valid}), 64'd0);
    @(negedge aclk);
    aresetn = 1'b1;

    $display("[TB] junk words before SOF, then packing vectors");
    for (int j = 0; j < 5; j++) applyStimulus(32'hDEAD0000 + 32'(j), 1'b0, j[0], 4'hF);
    bus.in_stream_tvalid = 1'b0;
    send_words(1, 0, 3, 1'b1, -1, -1, 1'b0);
    checkOutput("emit3_tready_low", 64'(bus.in_stream_tready), 64'd0);
    @(posedge aclk);
    #1;
    checkOutput("emit3_tready_back", 64'(bus.in_stream_tready), 64'd1);
    send_words(1, 3, WPF, 1'b1, -1, -1, 1'b0);
    wait_drain();
    checkOutput("f1_frame_count", 64'(frame_count), 64'd1);
    checkOutput("f1_checksum", 64'(checksum), 64'(exp_sum));
    checkOutput("f1_errors", 64'({err_sof, err_eol, err_keep}), 64'd0);

    $display("[TB] same frame under random backpressure");
    bp_en = 1'b1;
    send_words(1, 0, WPF, 1'b1, -1, -1, 1'b0);
    wait_drain();
    bp_en = 1'b0;
    checkOutput("f2_frame_count", 64'(frame_count), 64'd2);
    checkOutput("f2_checksum", 64'(checksum), 64'(exp_sum));

    $display("[TB] tuser mid-line resynchronises");
    send_words(3, 0, 2 * WPL + 3, 1'b1, -1, -1, 1'b0);
    send_words(4, 0, 1, 1'b1, -1, -1, 1'b0);
    checkOutput("resync_err_sof", 64'(err_sof), 64'd1);
    checkOutput("resync_frame_count", 64'(frame_count), 64'd2);
    send_words(4, 1, WPF, 1'b1, -1, -1, 1'b0);
    wait_drain();
    checkOutput("f3_frame_count", 64'(frame_count), 64'd3);
    checkOutput("f3_checksum", 64'(checksum), 64'(exp_sum));
    err_clear = 1'b1;
    @(negedge aclk);
    err_clear = 1'b0;
    checkOutput("err_sof_cleared", 64'(err_sof), 64'd0);

    $display("[TB] misplaced tlast, short tkeep, clear against set");
    send_words(5, 0, 18, 1'b1, WPL - 2, 10, 1'b0);
    checkOutput("err_eol_set", 64'(err_eol), 64'd1);
    checkOutput("err_keep_set", 64'(err_keep), 64'd1);
    checkOutput("err_sof_quiet", 64'(err_sof), 64'd0);
    send_words(5, 18, 19, 1'b1, -1, 18, 1'b1);
    checkOutput("clear_wins", 64'({err_sof, err_eol, err_keep}), 64'd0);
    send_words(5, 19, WPF, 1'b1, -1, -1, 1'b0);
    wait_drain();
    checkOutput("f4_frame_count", 64'(frame_count), 64'd4);
    checkOutput("f4_checksum", 64'(checksum), 64'(exp_sum));

    $display("[TB] frame without tuser on its first word");
    send_words(6, 0, WPF, 1'b0, -1, -1, 1'b0);
    wait_drain();
    checkOutput("missing_sof_err", 64'(err_sof), 64'd1);
    checkOutput("f5_frame_count", 64'(frame_count), 64'd5);
    checkOutput("f5_checksum", 64'(checksum), 64'(exp_sum));
    checkOutput("checksum_pulses", 64'(n_cs_pulses), 64'd5);

    $display("[TB] asynchronous reset mid-frame");
    send_words(7, 0, 6, 1'b1, -1, -1, 1'b0);
    wait_drain();
    #2;
    aresetn = 1'b0;
    #1;
    checkOutput("midreset_tready", 64'(bus.in_stream_tready), 64'd0);
    checkOutput("midreset_pix_valid", 64'(bus.pix_valid), 64'd0);
    checkOutput("midreset_frame_count", 64'(frame_count), 64'd0);
    checkOutput("midreset_checksum", 64'(checksum), 64'd0);
    checkOutput("midreset_errors", 64'({err_sof, err_eol, err_keep}), 64'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
